mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs (mem_* bundle) and drives the data-memory bus.
- Runs a req/gnt/rvalid handshake, builds byte enables and store data, and aligns and extends load data.
- Registers the MEM/WB stage, and drives lsu_stall so the upstream pipeline_en can be held low until the access completes.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- mem_result  in  32  ALU result; the byte address for loads and stores.
- mem_op2_selected  in  32  store data, unaligned (LSBs hold the value).
- mem_memory_write  in  1  store request.
- mem_memory_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 111 none.
- mem_memory_store_type  in  2  00 SB, 01 SH, 10 SW, 11 none.
- mem_mem_read  in  1  load request.
- mem_wb_reg_file  in  1  register-file write enable for this instruction.
- mem_wb_rd  in  5  destination register.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address ({mem_result[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- lsu_stall  out  1  1 = hold the pipeline (upstream pipeline_en = ~lsu_stall).
- wb_result  out  32  MEM/WB result (load data or pass-through mem_result).
- wb_reg_file  out  1  MEM/WB write enable.
- wb_rd  out  5  MEM/WB destination.

Behaviour:
- Access: mem_mem_read or mem_memory_write is 1. Both at once is illegal; the store takes priority.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - No access: lsu_stall=0 and the MEM/WB register captures the pass-through values each cycle.
  - Access: lsu_stall=1, go to REQ.
  - Any dmem_rvalid in IDLE is ignored.
- REQ:
  - dmem_req=1, lsu_stall=1; address, be, wdata and we are held stable until gnt.
  - On dmem_gnt: a store goes to DONE; a load goes to WAIT_R.
- WAIT_R:
  - dmem_req=0, lsu_stall=1.
  - On dmem_rvalid: capture the aligned/extended data into an internal load buffer, go to DONE.
  - A same-cycle rvalid with gnt in REQ is not supported; the responder returns rvalid no earlier than the cycle after gnt.
- DONE:
  - lsu_stall=0 for exactly one cycle.
  - MEM/WB captures the load buffer (load) or mem_result (store; wb_reg_file passes through and is 0 for stores).
  - Next state is IDLE, which evaluates the next instruction.
- Minimum latency with stall asserted:
  - Store: 3 cycles (IDLE, REQ with gnt, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT_R with rvalid, DONE).
  - gnt/rvalid wait states extend REQ/WAIT_R without limit.
- Byte enables (addr = mem_result[1:0]):
  - SB: 4'b0001<<addr.
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
- dmem_wdata:
  - SB: byte replicated ×4.
  - SH: half replicated ×2.
  - SW: as-is.
- Load select:
  - Byte lane = rdata[8*addr +: 8].
  - Half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Load type 111 with mem_mem_read=1 returns the word unmodified.
- Misalignment when MISALIGN_TRAP_EN is not defined: addr[0] is ignored for halves and addr[1:0] for words; the access goes ahead.
- Reset (async, any state):
  - FSM goes to IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, lsu_stall=0.
  - wb_result=0, wb_reg_file=0, wb_rd=0; the load buffer is cleared.
  - An outstanding bus transaction is abandoned; its later rvalid lands in IDLE and is dropped.
- dmem_req is driven from state only (registered-state decode); it has no combinational path from gnt.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, skips REQ/WAIT_R and goes IDLE→DONE.
  - No bus request is issued.
  - An extra output lsu_misalign (1 bit) is 1 in that DONE cycle, and MEM/WB wb_reg_file is forced to 0.
- When undefined: the port is absent and the ignore-low-bits behaviour applies.

Test Plan:
- Reset mid-load: assert rst_n=0 in WAIT_R → lsu_stall=0 and dmem_req=0 immediately; a later rvalid (rdata=32'hDEADBEEF) leaves wb_result=0.
- Non-memory op: mem_result=32'h12345678, wb_reg_file=1, rd=5 → lsu_stall never 1; next cycle wb_result=32'h12345678, wb_rd=5.
- SB:
  - Stimulus: addr=32'h1003, op2=32'h000000A5, gnt on first REQ cycle.
  - Response: dmem_be=4'b1000, dmem_wdata=32'hA5A5A5A5, dmem_addr=32'h1000, dmem_we=1; lsu_stall high exactly 2 cycles; wb_reg_file=0.
- LB vs LBU:
  - Stimulus: addr=32'h2002, rdata=32'h00800000.
  - Response: LB gives wb_result=32'hFFFFFF80; LBU gives 32'h00000080.
- LH with wait states:
  - Stimulus: addr=32'h2002, gnt after 3 cycles, rvalid 2 cycles later, rdata=32'h8001_0000.
  - Response: wb_result=32'hFFFF8001; lsu_stall high 7 cycles; dmem_req held with stable address throughout.
- Misaligned SW (MISALIGN_TRAP_EN defined): addr=32'h3001 → no dmem_req, lsu_misalign=1 for one cycle.
- Misaligned SW (undefined): addr=32'h3001 → bus write at 32'h3000 with be=4'b1111.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: dmem req/gnt/rvalid handshake, store lane steering,
// load align/extend and the MEM/WB register. Optional feature macro: MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] mem_op2_selected,
    input  logic            mem_memory_write,
    input  logic [2:0]      mem_memory_load_type,
    input  logic [1:0]      mem_memory_store_type,
    input  logic            mem_mem_read,
    input  logic            mem_wb_reg_file,
    input  logic [4:0]      mem_wb_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            lsu_stall,
`ifdef MISALIGN_TRAP_EN
    output logic            lsu_misalign,
`endif
    output logic [XLEN-1:0] wb_result,
    output logic            wb_reg_file,
    output logic [4:0]      wb_rd
);

    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_stall;

    logic              w_access;
    logic [1:0]        w_addr_lo;
    logic [BE_W-1:0]   w_be;
    logic [XLEN-1:0]   w_wdata;
    logic              w_misalign;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [XLEN-1:0]   w_load_data;

    logic              r_dmem_we;
    logic [XLEN-1:0]   r_dmem_addr;
    logic [BE_W-1:0]   r_dmem_be;
    logic [XLEN-1:0]   r_dmem_wdata;
    logic              r_is_load;
    logic              r_misalign;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_load_type;
    logic [XLEN-1:0]   r_load_buf;
    logic [XLEN-1:0]   r_wb_result;
    logic              r_wb_reg_file;
    logic [4:0]        r_wb_rd;

    assign w_access  = mem_mem_read | mem_memory_write;
    assign w_addr_lo = mem_result[1:0];

    // Store lane steering from the byte offset of the current instruction
    always_comb begin
        w_be    = '0;
        w_wdata = mem_op2_selected;
        case (mem_memory_store_type)
            ST_SB: begin
                w_be    = 4'b0001 << w_addr_lo;
                w_wdata = {4{mem_op2_selected[7:0]}};
            end
            ST_SH: begin
                w_be    = 4'b0011 << {w_addr_lo[1], 1'b0};
                w_wdata = {2{mem_op2_selected[15:0]}};
            end
            ST_SW:   w_be = 4'b1111;
            default: w_be = '0;
        endcase
    end

    // Misalignment only diverts the access when the trap build is selected
    always_comb begin
        w_misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (mem_memory_write) begin
            w_misalign = ((mem_memory_store_type == ST_SH) && w_addr_lo[0]) ||
                         ((mem_memory_store_type == ST_SW) && (w_addr_lo != 2'b00));
        end else begin
            w_misalign = (((mem_memory_load_type == LT_LH) || (mem_memory_load_type == LT_LHU))
                          && w_addr_lo[0]) ||
                         ((mem_memory_load_type == LT_LW) && (w_addr_lo != 2'b00));
        end
`endif
    end

    // Load alignment uses the offset/type latched when the access started
    always_comb begin
        w_lane_byte = dmem_rdata[7:0];
        case (r_addr_lo)
            2'd0:    w_lane_byte = dmem_rdata[7:0];
            2'd1:    w_lane_byte = dmem_rdata[15:8];
            2'd2:    w_lane_byte = dmem_rdata[23:16];
            default: w_lane_byte = dmem_rdata[31:24];
        endcase
        w_lane_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_load_type)
            LT_LB:   w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
            LT_LH:   w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
            LT_LBU:  w_load_data = {24'd0, w_lane_byte};
            LT_LHU:  w_load_data = {16'd0, w_lane_half};
            LT_LW:   w_load_data = dmem_rdata;
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_stall     = 1'b1;
                    w_state_nxt = w_misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (dmem_gnt) w_state_nxt = r_is_load ? S_WAIT_R : S_DONE;
            end
            S_WAIT_R: begin
                w_stall = 1'b1;
                if (dmem_rvalid) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus fields are latched on entry so they stay stable across gnt wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
            r_is_load    <= 1'b0;
            r_misalign   <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_load_type  <= 3'b111;
            r_load_buf   <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_access) begin
                r_dmem_we    <= mem_memory_write;
                r_dmem_addr  <= {mem_result[XLEN-1:2], 2'b00};
                r_dmem_be    <= mem_memory_write ? w_be : {BE_W{1'b1}};
                r_dmem_wdata <= mem_memory_write ? w_wdata : '0;
                r_is_load    <= ~mem_memory_write;
                r_misalign   <= w_misalign;
                r_addr_lo    <= w_addr_lo;
                r_load_type  <= mem_memory_load_type;
            end
            if ((r_state == S_WAIT_R) && dmem_rvalid) r_load_buf <= w_load_data;
        end
    end

    // MEM/WB: pass-through when idle, result on DONE, bubble while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_result   <= '0;
            r_wb_reg_file <= 1'b0;
            r_wb_rd       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_access) begin
                        r_wb_result   <= mem_result;
                        r_wb_reg_file <= mem_wb_reg_file;
                        r_wb_rd       <= mem_wb_rd;
                    end else begin
                        r_wb_reg_file <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_wb_result   <= r_is_load ? r_load_buf : mem_result;
                    r_wb_reg_file <= mem_wb_reg_file & ~r_misalign;
                    r_wb_rd       <= mem_wb_rd;
                end
                default: r_wb_reg_file <= 1'b0;
            endcase
        end
    end

    assign dmem_req    = (r_state == S_REQ);
    assign dmem_we     = r_dmem_we;
    assign dmem_addr   = r_dmem_addr;
    assign dmem_be     = r_dmem_be;
    assign dmem_wdata  = r_dmem_wdata;
    assign lsu_stall   = w_stall & rst_n;
    assign wb_result   = r_wb_result;
    assign wb_reg_file = r_wb_reg_file;
    assign wb_rd       = r_wb_rd;
`ifdef MISALIGN_TRAP_EN
    assign lsu_misalign = (r_state == S_DONE) & r_misalign;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: driver pushes expected MEM/WB and bus entries,
// independent monitors pop and compare; a responder models gnt/rvalid wait states.
module tb_mem_stage_lsu;

    typedef struct {
        logic [31:0] res;
        logic        chk_res;
        logic        rf;
        logic [4:0]  rd;
        int          stall;
        logic        mis;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_result;
    logic [31:0] mem_op2_selected;
    logic        mem_memory_write;
    logic [2:0]  mem_memory_load_type;
    logic [1:0]  mem_memory_store_type;
    logic        mem_mem_read;
    logic        mem_wb_reg_file;
    logic [4:0]  mem_wb_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        lsu_stall;
    logic [31:0] wb_result;
    logic        wb_reg_file;
    logic [4:0]  wb_rd;
`ifdef MISALIGN_TRAP_EN
    logic        lsu_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    logic     mon_en = 1'b0;

    logic        rsp_en       = 1'b0;
    int          rsp_gnt_wait = 0;
    int          rsp_rv_wait  = 0;
    logic [31:0] rsp_rdata    = '0;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mem_result            (mem_result),
        .mem_op2_selected      (mem_op2_selected),
        .mem_memory_write      (mem_memory_write),
        .mem_memory_load_type  (mem_memory_load_type),
        .mem_memory_store_type (mem_memory_store_type),
        .mem_mem_read          (mem_mem_read),
        .mem_wb_reg_file       (mem_wb_reg_file),
        .mem_wb_rd             (mem_wb_rd),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_be               (dmem_be),
        .dmem_wdata            (dmem_wdata),
        .dmem_gnt              (dmem_gnt),
        .dmem_rvalid           (dmem_rvalid),
        .dmem_rdata            (dmem_rdata),
        .lsu_stall             (lsu_stall),
`ifdef MISALIGN_TRAP_EN
        .lsu_misalign          (lsu_misalign),
`endif
        .wb_result             (wb_result),
        .wb_reg_file           (wb_reg_file),
        .wb_rd                 (wb_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: gnt after rsp_gnt_wait REQ cycles, rvalid rsp_rv_wait cycles after the WAIT_R entry
    initial begin
        logic pend;
        int   req_cnt;
        int   rv_cnt;
        pend = 1'b0; req_cnt = 0; rv_cnt = 0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rsp_en) begin
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b0;
                if (pend) begin
                    if (rv_cnt == rsp_rv_wait) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = rsp_rdata;
                        pend        = 1'b0;
                    end else begin
                        rv_cnt++;
                    end
                end
                if (dmem_req) begin
                    if (req_cnt == rsp_gnt_wait) begin
                        dmem_gnt = 1'b1;
                        req_cnt  = 0;
                        if (!dmem_we) begin
                            pend   = 1'b1;
                            rv_cnt = 0;
                        end
                    end else begin
                        req_cnt++;
                    end
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    // MEM/WB monitor: one entry per pipeline advance, plus stall-cycle count
    initial begin
        logic    adv_pend;
        int      stall_cnt;
        int      pend_stall;
        wb_exp_t e;
        adv_pend = 1'b0; stall_cnt = 0; pend_stall = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                adv_pend  = 1'b0;
                stall_cnt = 0;
            end else begin
                if (adv_pend) begin
                    adv_pend = 1'b0;
                    if (wb_q.size() == 0) begin
                        chk("wb_unexpected_advance", 32'd1, 32'd0);
                    end else begin
                        e = wb_q.pop_front();
                        if (e.chk_res) chk("wb_result", wb_result, e.res);
                        chk("wb_reg_file", {31'd0, wb_reg_file}, {31'd0, e.rf});
                        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                        chk("stall_cycles", pend_stall, e.stall);
                    end
                end
                if (lsu_stall) begin
                    stall_cnt++;
                end else begin
`ifdef MISALIGN_TRAP_EN
                    if (wb_q.size() > 0)
                        chk("lsu_misalign", {31'd0, lsu_misalign}, {31'd0, wb_q[0].mis});
`endif
                    adv_pend   = 1'b1;
                    pend_stall = stall_cnt;
                    stall_cnt  = 0;
                end
            end
        end
    end

    // Bus monitor: new request pops an entry; fields checked on every REQ cycle for stability
    initial begin
        logic     req_prev;
        logic     have_cur;
        bus_exp_t cur;
        req_prev = 1'b0; have_cur = 1'b0;
        cur = '{we: 1'b0, addr: '0, be: '0, wdata: '0};
        forever begin
            @(negedge clk);
            if (mon_en && dmem_req) begin
                if (!req_prev) begin
                    have_cur = 1'b0;
                    if (bus_q.size() == 0) begin
                        chk("dmem_req_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur      = bus_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    chk("dmem_addr", dmem_addr, cur.addr);
                    chk("dmem_we", {31'd0, dmem_we}, {31'd0, cur.we});
                    if (cur.we) begin
                        chk("dmem_be", {28'd0, dmem_be}, {28'd0, cur.be});
                        chk("dmem_wdata", dmem_wdata, cur.wdata);
                    end
                end
            end
            req_prev = dmem_req;
        end
    end

    function automatic wb_exp_t mk_wb(input logic [31:0] res, input logic chk_res, input logic rf,
                                      input logic [4:0] rd, input int stall, input logic mis);
        wb_exp_t e;
        e.res = res; e.chk_res = chk_res; e.rf = rf; e.rd = rd; e.stall = stall; e.mis = mis;
        return e;
    endfunction

    function automatic bus_exp_t mk_bus(input logic we, input logic [31:0] addr,
                                        input logic [3:0] be, input logic [31:0] wdata);
        bus_exp_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
        return b;
    endfunction

    // Present one instruction, queue its expectations, hold it until the pipeline advances
    task automatic issue(input logic [31:0] res, input logic [31:0] op2, input logic wr,
                         input logic rd_en, input logic [2:0] lt, input logic [1:0] st,
                         input logic rf, input logic [4:0] rd,
                         input logic [31:0] rdata, input int gw, input int rw,
                         input wb_exp_t we_exp, input logic has_bus, input bus_exp_t b_exp);
        int n;
        mem_result = res; mem_op2_selected = op2; mem_memory_write = wr; mem_mem_read = rd_en;
        mem_memory_load_type = lt; mem_memory_store_type = st;
        mem_wb_reg_file = rf; mem_wb_rd = rd;
        rsp_rdata = rdata; rsp_gnt_wait = gw; rsp_rv_wait = rw;
        wb_q.push_back(we_exp);
        if (has_bus) bus_q.push_back(b_exp);
        n = 0;
        @(negedge clk);
        while (lsu_stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("advance_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [31:0] res, input logic rf, input logic [4:0] rd);
        issue(res, 32'd0, 1'b0, 1'b0, 3'b111, 2'b11, rf, rd, 32'd0, 0, 0,
              mk_wb(res, 1'b1, rf, rd, 0, 1'b0), 1'b0, mk_bus(1'b0, '0, '0, '0));
    endtask

    initial begin
        bus_exp_t no_bus;
        int       n;
        logic     trap;
        no_bus = mk_bus(1'b0, '0, '0, '0);
`ifdef MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        rst_n = 1'b0;
        mem_result = '0; mem_op2_selected = '0; mem_memory_write = 1'b0; mem_mem_read = 1'b0;
        mem_memory_load_type = 3'b111; mem_memory_store_type = 2'b11;
        mem_wb_reg_file = 1'b0; mem_wb_rd = '0;

        repeat (2) @(negedge clk);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_lsu_stall", {31'd0, lsu_stall}, 32'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_wb_reg_file", {31'd0, wb_reg_file}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        #1 rst_n = 1'b1;

        // Reset while waiting for read data; the late rvalid must be dropped
        @(posedge clk); #1;
        rsp_en = 1'b1; rsp_gnt_wait = 0; rsp_rv_wait = 3; rsp_rdata = 32'hDEADBEEF;
        mem_result = 32'h4000; mem_mem_read = 1'b1; mem_memory_load_type = 3'b010;
        mem_wb_reg_file = 1'b1; mem_wb_rd = 5'd7;
        n = 0;
        @(negedge clk);
        while (!dmem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("midload_req_seen", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        chk("wait_r_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("wait_r_lsu_stall", {31'd0, lsu_stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_lsu_stall", {31'd0, lsu_stall}, 32'd0);
        chk("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_dmem_addr", dmem_addr, 32'd0);
        mem_result = '0; mem_mem_read = 1'b0; mem_memory_load_type = 3'b111;
        mem_wb_reg_file = 1'b0; mem_wb_rd = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("late_rvalid_wb_result", wb_result, 32'd0);
        chk("late_rvalid_wb_reg_file", {31'd0, wb_reg_file}, 32'd0);
        chk("late_rvalid_lsu_stall", {31'd0, lsu_stall}, 32'd0);

        @(posedge clk); #1;
        mon_en = 1'b1;

        // Non-memory pass-through
        nop(32'h12345678, 1'b1, 5'd5);
        // SB to byte 3
        issue(32'h1003, 32'h000000A5, 1'b1, 1'b0, 3'b111, 2'b00, 1'b0, 5'd0, 32'd0, 0, 0,
              mk_wb(32'h1003, 1'b1, 1'b0, 5'd0, 2, 1'b0), 1'b1,
              mk_bus(1'b1, 32'h1000, 4'b1000, 32'hA5A5A5A5));
        // LB vs LBU on lane 2
        issue(32'h2002, 32'd0, 1'b0, 1'b1, 3'b000, 2'b11, 1'b1, 5'd6, 32'h00800000, 0, 0,
              mk_wb(32'hFFFFFF80, 1'b1, 1'b1, 5'd6, 3, 1'b0), 1'b1,
              mk_bus(1'b0, 32'h2000, 4'd0, 32'd0));
        issue(32'h2002, 32'd0, 1'b0, 1'b1, 3'b100, 2'b11, 1'b1, 5'd6, 32'h00800000, 0, 0,
              mk_wb(32'h00000080, 1'b1, 1'b1, 5'd6, 3, 1'b0), 1'b1,
              mk_bus(1'b0, 32'h2000, 4'd0, 32'd0));
        // LH with 3 gnt wait states and 1 rvalid wait state
        issue(32'h2002, 32'd0, 1'b0, 1'b1, 3'b001, 2'b11, 1'b1, 5'd9, 32'h80010000, 3, 1,
              mk_wb(32'hFFFF8001, 1'b1, 1'b1, 5'd9, 7, 1'b0), 1'b1,
              mk_bus(1'b0, 32'h2000, 4'd0, 32'd0));
        nop(32'hA0A0_0001, 1'b0, 5'd3);
        // SH to the upper half
        issue(32'h1002, 32'hBEEF1234, 1'b1, 1'b0, 3'b111, 2'b01, 1'b0, 5'd0, 32'd0, 0, 0,
              mk_wb(32'h1002, 1'b1, 1'b0, 5'd0, 2, 1'b0), 1'b1,
              mk_bus(1'b1, 32'h1000, 4'b1100, 32'h12341234));
        // LHU lower half
        issue(32'h2000, 32'd0, 1'b0, 1'b1, 3'b101, 2'b11, 1'b1, 5'd10, 32'h1234F00D, 0, 0,
              mk_wb(32'h0000F00D, 1'b1, 1'b1, 5'd10, 3, 1'b0), 1'b1,
              mk_bus(1'b0, 32'h2000, 4'd0, 32'd0));
        // LW with one gnt wait state
        issue(32'h2004, 32'd0, 1'b0, 1'b1, 3'b010, 2'b11, 1'b1, 5'd11, 32'hCAFEBABE, 1, 0,
              mk_wb(32'hCAFEBABE, 1'b1, 1'b1, 5'd11, 4, 1'b0), 1'b1,
              mk_bus(1'b0, 32'h2004, 4'd0, 32'd0));
        // Load type 111 returns the raw word
        issue(32'h2001, 32'd0, 1'b0, 1'b1, 3'b111, 2'b11, 1'b1, 5'd12, 32'h89ABCDEF, 0, 0,
              mk_wb(32'h89ABCDEF, 1'b1, 1'b1, 5'd12, 3, 1'b0), 1'b1,
              mk_bus(1'b0, 32'h2000, 4'd0, 32'd0));
        // SB to byte 0 with high garbage in op2
        issue(32'h1000, 32'hFFFFFF5A, 1'b1, 1'b0, 3'b111, 2'b00, 1'b0, 5'd0, 32'd0, 0, 0,
              mk_wb(32'h1000, 1'b1, 1'b0, 5'd0, 2, 1'b0), 1'b1,
              mk_bus(1'b1, 32'h1000, 4'b0001, 32'h5A5A5A5A));
        // Misaligned SW and LH: trapped in the trap build, low bits ignored otherwise
        if (trap) begin
            issue(32'h3001, 32'h11223344, 1'b1, 1'b0, 3'b111, 2'b10, 1'b0, 5'd0, 32'd0, 0, 0,
                  mk_wb(32'd0, 1'b0, 1'b0, 5'd0, 1, 1'b1), 1'b0, no_bus);
            issue(32'h2003, 32'd0, 1'b0, 1'b1, 3'b001, 2'b11, 1'b1, 5'd13, 32'h7FFF0000, 0, 0,
                  mk_wb(32'd0, 1'b0, 1'b0, 5'd13, 1, 1'b1), 1'b0, no_bus);
        end else begin
            issue(32'h3001, 32'h11223344, 1'b1, 1'b0, 3'b111, 2'b10, 1'b0, 5'd0, 32'd0, 0, 0,
                  mk_wb(32'h3001, 1'b1, 1'b0, 5'd0, 2, 1'b0), 1'b1,
                  mk_bus(1'b1, 32'h3000, 4'b1111, 32'h11223344));
            issue(32'h2003, 32'd0, 1'b0, 1'b1, 3'b001, 2'b11, 1'b1, 5'd13, 32'h7FFF0000, 0, 0,
                  mk_wb(32'h00007FFF, 1'b1, 1'b1, 5'd13, 3, 1'b0), 1'b1,
                  mk_bus(1'b0, 32'h2000, 4'd0, 32'd0));
        end
        nop(32'h0000_0042, 1'b1, 5'd31);

        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("wb_queue_drained", wb_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
